obstacle_engine: RTL and testbench

//  Obstacle spawner, scroller and collision detector for the dinosaur game. Sits directly

---
 rtl/obstacle_engine.sv | 160 ++++++++++++++++
 tb/tb_obstacle_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_engine.sv
// Obstacle spawner, scroller and collision detector for the dinosaur game.
// Keeps the obstacle slot table and the saturating pass-count score.
module obstacle_engine #(
  parameter int          CLOCK_FREQUENCY = 25000000,
  parameter int          SCROLL_HZ       = 60,
  parameter int          NUM_OBS         = 4,
  parameter int          SCREEN_W        = 160,
  parameter int          OBS_W           = 8,
  parameter int          OBS_H           = 16,
  parameter int          DINO_X          = 20,
  parameter int          DINO_W          = 8,
  parameter int          GROUND          = 10,
  parameter int          MIN_GAP         = 40,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 reset_game,
  input  logic                 ld_game,
  input  logic                 calc_jump,
  input  logic                 create_obs,
  input  logic [15:0]          height,
  output logic                 gen,
  output logic                 kill,
  output logic [NUM_OBS-1:0]   obs_valid,
  output logic [8*NUM_OBS-1:0] obs_x,
  output logic [15:0]          score
);

  localparam int DIV_N = CLOCK_FREQUENCY / SCROLL_HZ;
  localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam int GAP_W = $clog2(MIN_GAP + 64);
  localparam int IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int CNT_W = $clog2(NUM_OBS + 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        score_q, score_d;
  logic               gen_q, gen_d;
  logic               kill_q, kill_d;
  logic [NUM_OBS-1:0] valid_q, valid_d;
  logic [7:0]         x_q [NUM_OBS];
  logic [7:0]         x_d [NUM_OBS];

  logic               run, tick, service, any_free, hit;
  logic [IDX_W-1:0]   free_idx;
  logic [CNT_W-1:0]   n_ret;
  logic [15:0]        alt;
  logic [16:0]        score_sum;

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    div_d     = div_q;
    gap_d     = gap_q;
    score_d   = score_q;
    gen_d     = gen_q;
    kill_d    = kill_q;
    valid_d   = valid_q;
    x_d       = x_q;
    n_ret     = '0;
    hit       = 1'b0;
    free_idx  = '0;
    alt       = '0;
    score_sum = '0;

    run      = ld_game | calc_jump | create_obs;
    tick     = run && (div_q == DIV_W'(DIV_N - 1));
    any_free = ~&valid_q;
    service  = create_obs & gen_q & any_free;

    if (run) div_d = tick ? '0 : div_q + 1'b1;
    if (tick && gap_q != '0) gap_d = gap_q - 1'b1;

    for (int i = 0; i < NUM_OBS; i++) begin
      if (tick && valid_q[i]) begin
        if (x_q[i] == 8'd0) begin
          valid_d[i] = 1'b0;
          n_ret      = n_ret + 1'b1;
        end else begin
          x_d[i] = x_q[i] - 1'b1;
        end
      end
    end
    score_sum = {1'b0, score_q} + {{(17-CNT_W){1'b0}}, n_ret};
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // Free slot comes from the pre-retire mask; a slot retiring now is not reused.
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end

    if (service) begin
      valid_d[free_idx] = 1'b1;
      x_d[free_idx]     = 8'(SCREEN_W - 1);
      gap_d             = GAP_W'(MIN_GAP) + GAP_W'(lfsr_q[5:0]);
      gen_d             = 1'b0;
    end else if (!gen_q) begin
      gen_d = (gap_q == '0) && any_free && run;
    end

    if (!height[15] && height >= 16'(GROUND)) alt = height - 16'(GROUND);
    for (int i = 0; i < NUM_OBS; i++) begin
      if (valid_q[i] && ({1'b0, x_q[i]} < 9'(DINO_X + DINO_W)) &&
          ({1'b0, x_q[i]} + 9'(OBS_W) > 9'(DINO_X)))
        hit = 1'b1;
    end
    if ((ld_game | calc_jump) && hit && alt < 16'(OBS_H)) kill_d = 1'b1;

    // Game restart clears everything except the LFSR, which keeps running.
    if (reset_game) begin
      div_d   = '0;
      gap_d   = GAP_W'(MIN_GAP);
      score_d = '0;
      gen_d   = 1'b0;
      kill_d  = 1'b0;
      valid_d = '0;
      for (int i = 0; i < NUM_OBS; i++) x_d[i] = 8'd0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge Clock) begin
    if (reset) begin
      div_q   <= '0;
      gap_q   <= GAP_W'(MIN_GAP);
      lfsr_q  <= LFSR_SEED;
      score_q <= '0;
      gen_q   <= 1'b0;
      kill_q  <= 1'b0;
      valid_q <= '0;
      // NOTE: the slot table is a handful of flops whose x is visible on obs_x,
      // so it is reset rather than left as an unreset memory.
      for (int i = 0; i < NUM_OBS; i++) x_q[i] <= 8'd0;
    end else begin
      div_q   <= div_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      gen_q   <= gen_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      for (int i = 0; i < NUM_OBS; i++) x_q[i] <= x_d[i];
    end
  end

  always_comb begin
    obs_x = '0;
    for (int i = 0; i < NUM_OBS; i++) obs_x[8*i +: 8] = x_q[i];
  end

  assign gen       = gen_q;
  assign kill      = kill_q;
  assign obs_valid = valid_q;
  assign score     = score_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// Directed bench for obstacle_engine: spawn handshake, scrolling, pause,
// collision, retirement scoring, slot reuse and game restart.
module tb_obstacle_engine;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        Clock;
  logic        reset, reset_game, ld_game, calc_jump, create_obs;
  logic [15:0] height;
  logic        gen, kill;
  logic [3:0]  obs_valid;
  logic [31:0] obs_x;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  obstacle_engine #(
    .CLOCK_FREQUENCY(100),
    .SCROLL_HZ      (10),
    .MIN_GAP        (2),
    .LFSR_SEED      (SEED)
  ) dut (
    .Clock     (Clock),
    .reset     (reset),
    .reset_game(reset_game),
    .ld_game   (ld_game),
    .calc_jump (calc_jump),
    .create_obs(create_obs),
    .height    (height),
    .gen       (gen),
    .kill      (kill),
    .obs_valid (obs_valid),
    .obs_x     (obs_x),
    .score     (score)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference Galois LFSR (x^16+x^14+x^13+x^11+1), reloaded only by reset.
  logic [15:0] lfsr_m;
  always @(posedge Clock) begin
    if (reset) lfsr_m <= SEED;
    else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic wait_x(input int slot, input logic [7:0] val, input string tag);
    int n = 0;
    while (obs_x[8*slot +: 8] != val && n < 3000) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_gen(input string tag);
    int n = 0;
    while (!gen && n < 1000) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(gen), 32'd1);
  endtask

  // Counts slot-0 scroll ticks from a spawn until gen rises again and checks
  // gen rose exactly one cycle after the tick that emptied the gap.
  task automatic measure_gap(input int exp, input string tag);
    int n = 0, ticks = 0, since = 0;
    logic seen = 1'b0;
    logic [7:0] prev;
    while (!seen && n < 1000) begin
      prev = obs_x[7:0];
      cyc(1);
      if (obs_x[7:0] != prev) begin
        ticks++;
        since = 0;
      end else begin
        since++;
      end
      if (gen) seen = 1'b1;
      n++;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_ticks"}, 32'(ticks), 32'(exp));
    check({tag, "_lat"}, 32'(since), 32'd1);
  endtask

  int         exp_gap;
  logic [7:0] saved, x1p;

  initial begin
    reset = 1'b1; reset_game = 1'b0; ld_game = 1'b0; calc_jump = 1'b0;
    create_obs = 1'b0; height = 16'd10;
    cyc(3);
    check("rst_gen",   32'(gen),       32'd0);
    check("rst_kill",  32'(kill),      32'd0);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_x",     obs_x,          32'd0);
    check("rst_score", 32'(score),     32'd0);

    // First spawn: gap=2 ticks, gen one cycle after tick 2
    reset = 1'b0; ld_game = 1'b1;
    cyc(20);
    check("gen_pre",  32'(gen), 32'd0);
    cyc(1);
    check("gen_rise", 32'(gen), 32'd1);
    exp_gap = 2 + int'(lfsr_m[5:0]);
    create_obs = 1'b1; cyc(1); create_obs = 1'b0;
    check("sp_valid", 32'(obs_valid),  32'd1);
    check("sp_x",     32'(obs_x[7:0]), 32'd159);
    check("sp_gen",   32'(gen),        32'd0);
    measure_gap(exp_gap, "gap1");

    // Pause with divider at 3: everything frozen, tick 7 run cycles after resume
    cyc(2);
    saved = obs_x[7:0];
    ld_game = 1'b0;
    cyc(50);
    check("pause_x",   32'(obs_x[7:0]), 32'(saved));
    check("pause_gen", 32'(gen),        32'd1);
    ld_game = 1'b1;
    cyc(6);
    check("resume_hold", 32'(obs_x[7:0]), 32'(saved));
    cyc(1);
    check("resume_tick", 32'(obs_x[7:0]), 32'(saved - 8'd1));

    // Collision at ground height, then retirement
    wait_x(0, 8'd27, "to_x27a");
    check("kill_pre", 32'(kill), 32'd0);
    cyc(1);
    check("kill_hit", 32'(kill), 32'd1);
    wait_x(0, 8'd0, "to_x0a");
    cyc(9);
    check("ret_hold_v", 32'(obs_valid), 32'd1);
    check("ret_hold_s", 32'(score),     32'd0);
    cyc(1);
    check("ret_valid",  32'(obs_valid), 32'd0);
    check("ret_score",  32'(score),     32'd1);
    check("kill_stick", 32'(kill),      32'd1);

    // Game restart
    reset_game = 1'b1; cyc(1); reset_game = 1'b0;
    check("rg_kill",  32'(kill),      32'd0);
    check("rg_score", 32'(score),     32'd0);
    check("rg_valid", 32'(obs_valid), 32'd0);
    check("rg_gen",   32'(gen),       32'd0);
    check("rg_x",     obs_x,          32'd0);

    // Jump high enough: no kill; LFSR must not have been reloaded
    height = 16'd40;
    cyc(20);
    check("rg_gen_pre",  32'(gen), 32'd0);
    cyc(1);
    check("rg_gen_rise", 32'(gen), 32'd1);
    exp_gap = 2 + int'(lfsr_m[5:0]);
    create_obs = 1'b1; cyc(1); create_obs = 1'b0;
    measure_gap(exp_gap, "gap2");
    wait_x(0, 8'd27, "to_x27b");
    check("jump_nokill_a", 32'(kill), 32'd0);
    height = 16'd26;
    wait_x(0, 8'd12, "to_x12");
    check("jump_nokill_b", 32'(kill), 32'd0);
    height = 16'd40;
    wait_x(0, 8'd0, "to_x0b");
    cyc(10);
    check("jump_valid", 32'(obs_valid), 32'd0);
    check("jump_score", 32'(score),     32'd1);
    check("jump_kill",  32'(kill),      32'd0);

    // Fill all slots, servicing when the gap draw is small
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      wait_gen("fill_gen");
      while (lfsr_m[5:0] > 6'd3 && n < 300) begin
        cyc(1);
        n++;
      end
      check("fill_lfsr", 32'(n < 300), 32'd1);
      create_obs = 1'b1; cyc(1); create_obs = 1'b0;
      check("fill_mask", 32'(obs_valid), (32'd1 << (k + 1)) - 32'd1);
    end
    cyc(80);
    check("full_gen", 32'(gen), 32'd0);

    // Oldest slot retires -> gen next cycle; reuse it on a tick edge
    begin
      int n = 0;
      while (obs_valid == 4'hF && n < 3000) begin
        cyc(1);
        n++;
      end
      check("free_seen", 32'(n < 3000), 32'd1);
    end
    check("free_mask", 32'(obs_valid), 32'hE);
    check("free_gen0", 32'(gen),       32'd0);
    cyc(1);
    check("free_gen1", 32'(gen), 32'd1);
    cyc(8);
    x1p = obs_x[15:8];
    create_obs = 1'b1; cyc(1); create_obs = 1'b0;
    check("reuse_x0",    32'(obs_x[7:0]),  32'd159);
    check("reuse_x1",    32'(obs_x[15:8]), 32'(x1p - 8'd1));
    check("reuse_mask",  32'(obs_valid),   32'hF);
    check("reuse_score", 32'(score),       32'd2);

    // Altitude 15 is still low enough to collide
    wait_x(0, 8'd40, "to_x40");
    height = 16'd25;
    wait_x(0, 8'd27, "to_x27c");
    check("alt15_pre", 32'(kill), 32'd0);
    cyc(1);
    check("alt15_hit", 32'(kill),  32'd1);
    check("score5",    32'(score), 32'd5);

    reset_game = 1'b1; cyc(1); reset_game = 1'b0;
    check("rg2_kill",  32'(kill),      32'd0);
    check("rg2_score", 32'(score),     32'd0);
    check("rg2_valid", 32'(obs_valid), 32'd0);
    check("rg2_gen",   32'(gen),       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
